layer_serializer: RTL and testbench

Parallel-to-serial converter between two fully-connected layers. Captures the NN-wide result vector produced by one layer's neurons, which all assert their per-neuron valid together. Replays the vector one element per clock as the single-stream input (valid + data) that the next layer's neurons consume. Has no backpressure: the downstream layer accepts one input per cycle unconditionally.

---
 rtl/layer_serializer_pkg.sv | 23 ++
 rtl/layer_serializer.sv | 196 +++++++++++++++++++
 tb/tb_layer_serializer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_serializer_pkg.sv
// -----------------------------------------------------------------------------
// layer_serializer_pkg
//   Shared definitions for the layer-to-layer serializer.
//   - ser_state_t : replay controller state (IDLE / SHIFT)
//   - idx_width() : width of the element index register for a vector of n
//                   elements; never narrower than one bit so NN == 1 still has
//                   a real (constant-zero) index register.
// -----------------------------------------------------------------------------
package layer_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/layer_serializer.sv
// -----------------------------------------------------------------------------
// layer_serializer
//   Parallel-to-serial converter between two fully-connected layers. Captures
//   the whole result vector of the producing layer when every neuron asserts
//   its valid on the same edge, then replays it one element per clock, element
//   0 first, as the single input stream of the consuming layer. No
//   backpressure: the consumer takes one element every cycle.
//
// Parameters
//   NN        : number of elements in a vector (neurons in producing layer)
//   dataWidth : width of one element
//
// Ports
//   clk      in   clock, rising edge
//   rstn     in   synchronous reset, active HIGH (name kept for drop-in use)
//   i_valid  in   [NN]            per-neuron valid of producing layer
//   i_data   in   [NN*dataWidth]  element k at i_data[k*dataWidth +: dataWidth]
//   o_valid  out  serial element valid (next layer x_valid)
//   o_data   out  [dataWidth]     serial element (next layer x_in), 0 when idle
//   o_last   out  marks element NN-1
//   busy     out  high while a vector is being replayed
//   overrun  out  sticky: a full vector arrived mid-replay and was dropped
//   partial  out  sticky: some but not all valids were seen together
//
// Timing
//   A capture on edge T presents element k in the cycle after edge T+k. A new
//   vector captured on the edge that ends the last element continues the
//   stream with no gap. All outputs come from registers.
// -----------------------------------------------------------------------------
module layer_serializer
    import layer_serializer_pkg::*;
#(
    parameter int unsigned NN        = 30,
    parameter int unsigned dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic                    o_last,
    output logic                    busy,
    output logic                    overrun,
    output logic                    partial
);

    localparam int unsigned   IW       = idx_width(NN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    ser_state_t          state;
    ser_state_t          state_d;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_d;

    logic [dataWidth-1:0] vec_buf [NN];

    logic                 capture;
    logic                 part_seen;
    logic                 at_last;
    logic                 load;
    logic                 drop;

    logic                 o_valid_d;
    logic                 o_last_d;
    logic [dataWidth-1:0] o_data_d;

    assign capture   = &i_valid;
    assign part_seen = (|i_valid) && !capture;
    assign at_last   = (idx == LAST_IDX);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    //   idx is the index of the element shown on the outputs during the
    //   current SHIFT cycle. A capture while the last element is on the
    //   outputs reloads and restarts at 0 without passing through IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state;
        idx_d   = idx;
        load    = 1'b0;
        drop    = 1'b0;

        unique case (state)
            IDLE: begin
                if (capture) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (at_last) begin
                    idx_d = '0;
                    if (capture) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx + IW'(1);
                    drop  = capture;
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (next values of the output registers)
    //   On a load the buffer is written on the same edge, so element 0 is
    //   taken straight from i_data rather than from vec_buf.
    // -------------------------------------------------------------------------
    always_comb begin
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
        o_data_d  = '0;

        if (state_d == SHIFT) begin
            o_valid_d = 1'b1;
            o_last_d  = (idx_d == LAST_IDX);
            if (load) begin
                o_data_d = i_data[0 +: dataWidth];
            end else begin
                o_data_d = vec_buf[idx_d];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output and sticky flag registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
            overrun <= 1'b0;
            partial <= 1'b0;
        end else begin
            o_valid <= o_valid_d;
            o_last  <= o_last_d;
            o_data  <= o_data_d;
            if (drop) begin
                overrun <= 1'b1;
            end
            if (part_seen) begin
                partial <= 1'b1;
            end
        end
    end

    assign busy = (state == SHIFT);

    // -------------------------------------------------------------------------
    // Vector buffer: written only on a capture, never reset, read by index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned k = 0; k < NN; k++) begin
                vec_buf[k] <= i_data[k*dataWidth +: dataWidth];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Internal invariants
    // -------------------------------------------------------------------------
    idx_in_range: assert property (@(posedge clk) disable iff (rstn)
        idx <= LAST_IDX);

    idle_data_zero: assert property (@(posedge clk) disable iff (rstn)
        !o_valid |-> (o_data == '0));

    last_implies_valid: assert property (@(posedge clk) disable iff (rstn)
        o_last |-> o_valid);

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rstn;
    int unsigned cyc = 0;

    // NN = 4 instance
    logic [3:0]  i_valid4;
    logic [63:0] i_data4;
    logic        o_valid4, o_last4, busy4, overrun4, partial4;
    logic [15:0] o_data4;

    // NN = 1 instance
    logic [0:0]  i_valid1;
    logic [15:0] i_data1;
    logic        o_valid1, o_last1, busy1, overrun1, partial1;
    logic [15:0] o_data1;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    bit   ev4, ev1;
    bit   mon_en = 0;

    int n_total = 0;
    int n_pass  = 0;

    layer_serializer #(.NN(4), .dataWidth(16)) u_dut4 (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (i_valid4),
        .i_data  (i_data4),
        .o_valid (o_valid4),
        .o_data  (o_data4),
        .o_last  (o_last4),
        .busy    (busy4),
        .overrun (overrun4),
        .partial (partial4)
    );

    layer_serializer #(.NN(1), .dataWidth(16)) u_dut1 (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (i_valid1),
        .i_data  (i_data1),
        .o_valid (o_valid1),
        .o_data  (o_data1),
        .o_last  (o_last1),
        .busy    (busy1),
        .overrun (overrun1),
        .partial (partial1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitors: an element is due when the head of the queue has reached its
    // cycle; o_valid/busy must match that, and data/last must match the head.
    always @(negedge clk) begin
        if (mon_en) begin
            ev4 = (q4.size() > 0) && (q4[0].cyc <= cyc);
            check("o_valid4", {31'b0, o_valid4}, {31'b0, ev4});
            check("busy4", {31'b0, busy4}, {31'b0, ev4});
            if (ev4) begin
                e4 = q4.pop_front();
                check("o_data4", {16'b0, o_data4}, {16'b0, e4.data});
                check("o_last4", {31'b0, o_last4}, {31'b0, e4.last});
            end else begin
                check("o_data4_idle", {16'b0, o_data4}, 32'd0);
                check("o_last4_idle", {31'b0, o_last4}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            ev1 = (q1.size() > 0) && (q1[0].cyc <= cyc);
            check("o_valid1", {31'b0, o_valid1}, {31'b0, ev1});
            check("busy1", {31'b0, busy1}, {31'b0, ev1});
            if (ev1) begin
                e1 = q1.pop_front();
                check("o_data1", {16'b0, o_data1}, {16'b0, e1.data});
                check("o_last1", {31'b0, o_last1}, {31'b0, e1.last});
            end else begin
                check("o_data1_idle", {16'b0, o_data1}, 32'd0);
                check("o_last1_idle", {31'b0, o_last1}, 32'd0);
            end
        end
    end

    // Drive one vector for one cycle (call at a negedge). When it is expected
    // to be captured, the NN=4 elements are due on cycles T..T+3.
    task automatic send4(input logic [3:0] v, input logic [63:0] d, input bit captured);
        int unsigned t;
        exp_t e;
        t = cyc + 1;
        i_valid4 = v;
        i_data4  = d;
        if (captured) begin
            for (int k = 0; k < 4; k++) begin
                e.data = d[k*16 +: 16];
                e.last = (k == 3);
                e.cyc  = t + k;
                q4.push_back(e);
            end
        end
        @(negedge clk);
        i_valid4 = '0;
        i_data4  = '0;
    endtask

    task automatic send1(input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.last = 1'b1;
        e.cyc  = cyc + 1;
        q1.push_back(e);
        i_valid1 = 1'b1;
        i_data1  = d;
        @(negedge clk);
        i_valid1 = '0;
        i_data1  = '0;
    endtask

    // Reset for one edge; anything due on or after that edge is discarded.
    task automatic pulse_reset();
        rstn = 1'b1;
        while (q4.size() > 0 && q4[q4.size()-1].cyc >= cyc + 1) void'(q4.pop_back());
        while (q1.size() > 0 && q1[q1.size()-1].cyc >= cyc + 1) void'(q1.pop_back());
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] b2b1 [4];

    initial begin
        rstn     = 1'b1;
        i_valid4 = '0;
        i_data4  = '0;
        i_valid1 = '0;
        i_data1  = '0;
        b2b1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        repeat (2) @(negedge clk);
        mon_en = 1;
        rstn   = 1'b0;

        // reset state
        check("rst_o_valid4", {31'b0, o_valid4}, 32'd0);
        check("rst_o_data4", {16'b0, o_data4}, 32'd0);
        check("rst_busy4", {31'b0, busy4}, 32'd0);
        check("rst_overrun4", {31'b0, overrun4}, 32'd0);
        check("rst_partial4", {31'b0, partial4}, 32'd0);
        check("rst_o_valid1", {31'b0, o_valid1}, 32'd0);
        check("rst_overrun1", {31'b0, overrun1}, 32'd0);

        // basic: expect 1,2,3,4
        send4(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1);
        idle(6);

        // back-to-back: second vector on the edge ending element 3
        send4(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1);
        idle(3);
        send4(4'hF, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 1);
        idle(8);
        check("b2b_overrun4", {31'b0, overrun4}, 32'd0);

        // overrun: second vector sampled while idx == 1
        send4(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1);
        idle(1);
        send4(4'hF, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 0);
        idle(6);
        check("ovr_overrun4", {31'b0, overrun4}, 32'd1);
        check("ovr_partial4", {31'b0, partial4}, 32'd0);

        // partial: not captured, flag set; later full vector still replays
        send4(4'b0101, {16'h0d00, 16'h0c00, 16'h0b00, 16'h0a00}, 0);
        idle(3);
        check("par_partial4", {31'b0, partial4}, 32'd1);
        send4(4'hF, {16'hA4A4, 16'hA3A3, 16'hA2A2, 16'hA1A1}, 1);
        idle(6);
        check("par_overrun4_sticky", {31'b0, overrun4}, 32'd1);
        check("par_partial4_sticky", {31'b0, partial4}, 32'd1);

        // reset while element 2 is on the outputs
        send4(4'hF, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1);
        idle(2);
        pulse_reset();
        check("mid_o_valid4", {31'b0, o_valid4}, 32'd0);
        check("mid_busy4", {31'b0, busy4}, 32'd0);
        check("mid_o_data4", {16'b0, o_data4}, 32'd0);
        check("mid_overrun4", {31'b0, overrun4}, 32'd0);
        check("mid_partial4", {31'b0, partial4}, 32'd0);
        send4(4'hF, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 1);
        idle(6);

        // NN = 1: single element, then a capture on every cycle
        send1(16'hABCD);
        idle(3);
        for (int i = 0; i < 4; i++) send1(b2b1[i]);
        idle(4);
        check("nn1_overrun1", {31'b0, overrun1}, 32'd0);
        check("nn1_partial1", {31'b0, partial1}, 32'd0);

        check("q4_drained", q4.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
